mult_seq: RTL
=============

# mult_seq

Parametrised sequential shift-add multiplier; next generation of the 16x16 `mult_32` ASM core.

- Generalises operand width.
- Adds a signed/unsigned mode, a busy flag and optional early termination on the multiplier magnitude.
- Keeps the same `init`/`done` handshake, so it drops into the core's arithmetic path wherever `mult_32` is used.

## Interface

Parameters:
- `WIDTH`, 16: operand width in bits; legal range 2 to 64.
- `EARLY_TERM`, 1: 1 = stop iterating once the remaining multiplier bits are zero; 0 = always run `WIDTH` iterations (fixed latency, `mult_32`-compatible).

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `init`, in, 1: start request, level-sampled.
- `sgn`, in, 1: 1 = operands are two's complement, 0 = unsigned; sampled with `init`.
- `A`, in, `WIDTH`: multiplicand.
- `B`, in, `WIDTH`: multiplier.
- `pp`, out, `2*WIDTH`: product, registered.
- `done`, out, 1: result valid.
- `busy`, out, 1: operation in progress.

## Operation

FSM states: `IDLE`, `RUN`, `FIX`, `DONE`.

`IDLE`:
- `busy`=0, `done`=0.
- When `init`=1 at a rising edge:
  - capture the magnitudes of `A` and `B` into `WIDTH`-bit registers (two's-complement abs when `sgn`=1; `-2^(WIDTH-1)` gives `2^(WIDTH-1)` unsigned);
  - capture neg = `sgn & (A[msb]^B[msb])`;
  - clear the accumulator (`2*WIDTH` bits) and the iteration count;
  - go to `RUN`.

`RUN`, one iteration per cycle:
- If `breg[0]`, acc += `areg` (`areg` is zero-extended to `2*WIDTH`).
- `areg` <<= 1 (held in `2*WIDTH` bits); `breg` >>= 1; count++.
- Exit to `FIX` when either:
  - count reaches `WIDTH`, or
  - `EARLY_TERM`=1 and the shifted `breg` is zero.
- At least one `RUN` cycle always executes, including when `B`=0.

`FIX`:
- `pp` <= neg ? -acc : acc, truncated to `2*WIDTH` bits.
- Go to `DONE`.

`DONE`:
- `done`=1.
- Stay while `init`=1; go to `IDLE` on the first edge with `init`=0.
- A held `init` therefore never triggers a second operation.

Other rules:
- `busy`=1 in `RUN`, `FIX` and `DONE`.
- `init` is ignored outside `IDLE`.
- `A`, `B` and `sgn` may change freely after capture.
- `pp` holds its value until the next `FIX`; it is valid whenever `done`=1 and stays readable in `IDLE`.

## Timing

- Reset values: `pp`=0, `done`=0, `busy`=0, state `IDLE`.
- Reset mid-operation aborts the operation; outputs take their reset values on that edge.
- `rst` has priority over `init` on the same edge.
- Iteration count R:
  - `EARLY_TERM`=0: R=`WIDTH`.
  - `EARLY_TERM`=1: R = max(1, index of the highest set bit of |B| + 1).
- Latency, with `init` sampled at edge k:
  - `RUN` occupies edges k+1 to k+R;
  - `FIX` is at edge k+R+1;
  - `done` is high after edge k+R+2 (first cycle with `done`=1).
- Minimum start-to-start spacing: R+3 cycles (`init` must be low for at least one edge in `DONE`).
- No combinational path from inputs to outputs.

## Structure

- Package `mult_pkg`:
  - state enum `mult_state_t` {`IDLE`, `RUN`, `FIX`, `DONE`};
  - localparam helper for the count width, `$clog2(WIDTH+1)`.
- Natural split: sub-module `mult_seq_ctrl` holds the FSM, count and exit condition and drives the datapath enables.
- Datapath (abs, shift registers, accumulator, negate) stays in the top module.

## Test plan

All cases use `WIDTH`=16, `EARLY_TERM`=1 unless stated.

1. Unsigned, `A`=0x00F7, `B`=0x007F, `init` held for 2 cycles:
   - `pp`=0x00007A89;
   - R=7; `done` first high after edge k+9;
   - `done` stays high until `init` drops, and no second operation starts.
2. Unsigned, `A`=0xFFFF, `B`=0xFFFF: `pp`=0xFFFE0001, R=16.
3. With `EARLY_TERM`=0, the same operands as scenario 1 give the same `pp` with `done` after edge k+18.
4. Signed cases:
   - `A`=0x8000, `B`=0x0002 → `pp`=0xFFFF0000;
   - `A`=0x8000, `B`=0x8000 → `pp`=0x40000000;
   - `A`=0xFFFF, `B`=0xFFFF → `pp`=0x00000001 with R=1;
   - unsigned `A`=0x8000, `B`=0x0002 → `pp`=0x00010000.
5. `B`=0, `A`=0x1234: R=1, `pp`=0, `done` after edge k+3.
6. Reset and ignored-start checks:
   - `rst` asserted on the 4th `RUN` cycle: `busy`, `done` and `pp` are 0 on the next edge.
   - A fresh `init` afterwards completes correctly.
   - An `init` pulse while `busy` is ignored.
   - Random unsigned/signed operands are checked against a reference model with `WIDTH`=8 and `WIDTH`=32.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helper for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;

   // Iteration counter width: enough to hold 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control FSM for mult_seq: sequences load/iterate/fix/done and counts iterations.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_TERM = 1'b1
)(
   input  logic clk,
   input  logic rst,
   input  logic i_init,
   input  logic i_b_rest_zero,
   output logic o_load,
   output logic o_run,
   output logic o_fix,
   output logic o_done,
   output logic o_busy
);

   localparam int CW = cnt_w(WIDTH);

   mult_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic          r_busy;
   logic          w_last;

   // Last iteration: this cycle brings the count to WIDTH, or no multiplier bits remain.
   assign w_last = (r_cnt == CW'(WIDTH - 1)) || (EARLY_TERM && i_b_rest_zero);

   assign o_load = (r_state == IDLE) && i_init;
   assign o_run  = (r_state == RUN);
   assign o_fix  = (r_state == FIX);
   assign o_done = r_done;
   assign o_busy = r_busy;

   // done trails the DONE state by one edge so it stays up for the cycle after leaving it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_busy <= 1'b1;
         case (r_state)
            IDLE: begin
               r_busy <= i_init;
               if (i_init) begin
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) r_state <= FIX;
            end
            FIX: r_state <= DONE;
            DONE: begin
               r_done <= 1'b1;
               if (!i_init) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mult_seq.sv
// Parametrised sequential shift-add multiplier with signed mode and early termination.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_TERM = 1'b1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] pp,
   output logic               done,
   output logic               busy
);

   logic               w_load;
   logic               w_run;
   logic               w_fix;
   logic               w_b_rest_zero;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [WIDTH-1:0]   r_breg;
   logic [2*WIDTH-1:0] r_areg;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_pp;
   logic               r_neg;

   // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
   assign w_a_abs = (sgn && A[WIDTH-1]) ? -A : A;
   assign w_b_abs = (sgn && B[WIDTH-1]) ? -B : B;

   assign w_b_rest_zero = (r_breg[WIDTH-1:1] == '0);

   mult_seq_ctrl #(
      .WIDTH      (WIDTH),
      .EARLY_TERM (EARLY_TERM)
   ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .i_init        (init),
      .i_b_rest_zero (w_b_rest_zero),
      .o_load        (w_load),
      .o_run         (w_run),
      .o_fix         (w_fix),
      .o_done        (done),
      .o_busy        (busy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_areg <= '0;
         r_breg <= '0;
         r_acc  <= '0;
         r_neg  <= 1'b0;
         r_pp   <= '0;
      end else if (w_load) begin
         r_areg <= {{WIDTH{1'b0}}, w_a_abs};
         r_breg <= w_b_abs;
         r_acc  <= '0;
         r_neg  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
      end else if (w_run) begin
         if (r_breg[0]) r_acc <= r_acc + r_areg;
         r_areg <= r_areg << 1;
         r_breg <= r_breg >> 1;
      end else if (w_fix) begin
         r_pp <= r_neg ? -r_acc : r_acc;
      end
   end

   assign pp = r_pp;

endmodule
